// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared MIPS core types for the iterative multiply/divide unit.
// The CPU decode maps F_MULT/F_MULTU/F_DIV/F_DIVU onto muldiv_op_t.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } muldiv_state_t;

    function automatic logic md_is_div(muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Issue/result bus between the CPU HI/LO path (master) and the muldiv unit (slave).
interface mips_cpu_muldiv_if #(
    parameter int WIDTH = 32
);
    import mips_cpu_pkg::*;

    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mips_cpu_muldiv.sv
// Radix-2 multiply (shift-add) / restoring divide unit with fixed latency,
// sharing one {acc_hi, acc_lo} accumulator and a WIDTH+1 bit adder/subtractor.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_enable,
    mips_cpu_muldiv_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t     state, state_next;
    logic [CW-1:0]     counter;
    logic              div_op, sign_q, sign_r, div_zero;
    logic [WIDTH-1:0]  acc_hi, acc_lo, b_reg;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic              busy_q, done_q;

    logic              accept, signed_op;
    logic [WIDTH-1:0]  a_abs, b_abs;
    logic [WIDTH:0]    mul_sum, div_shift, div_sub;
    logic              div_ge;

    // busy_q also covers the done cycle, so a start there is ignored too.
    assign accept    = (state == IDLE) && bus.start && !busy_q;
    assign signed_op = md_is_signed(bus.op);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (counter == CW'(WIDTH - 1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_abs = (signed_op && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
        b_abs = (signed_op && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;

        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_reg} : '0);

        // rem < divisor, so the shifted value minus the divisor always fits in
        // WIDTH+1 bits and the MSB acts as the borrow.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_sub   = div_shift - {1'b0, b_reg};
        div_ge    = !div_sub[WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            div_op   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            b_reg    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (clk_enable) begin
            state  <= state_next;
            // Status outputs are registered off the state, never off start.
            busy_q <= accept || (state != IDLE);
            done_q <= (state == DONE);

            unique case (state)
                IDLE: if (accept) begin
                    div_op   <= md_is_div(bus.op);
                    sign_q   <= signed_op && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                    sign_r   <= signed_op && bus.operand_a[WIDTH-1];
                    div_zero <= md_is_div(bus.op) && (bus.operand_b == '0);
                    counter  <= '0;
                    acc_hi   <= '0;
                    if (md_is_div(bus.op)) begin
                        acc_lo <= a_abs;
                        b_reg  <= b_abs;
                    end else begin
                        acc_lo <= b_abs;
                        b_reg  <= a_abs;
                    end
                end
                RUN: begin
                    counter <= counter + 1'b1;
                    if (div_op) begin
                        acc_hi <= div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (div_op) begin
                        // Divide by zero leaves |a| in the remainder; the dividend
                        // sign fix turns that back into the raw operand_a.
                        lo_q <= div_zero ? '1 : (sign_q ? -acc_lo : acc_lo);
                        hi_q <= sign_r ? -acc_hi : acc_hi;
                    end else begin
                        {hi_q, lo_q} <= sign_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
                    end
                end
                DONE: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: an arithmetic/timing model checked every
// cycle, plus literal expectations for each directed operation.
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

    localparam int LAT = 34;

    logic clk = 1'b0;
    logic reset;
    logic clk_enable;
    logic chk_on = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    mips_cpu_muldiv_if #(.WIDTH(32)) bus ();

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Plain-arithmetic reference result {hi, lo}.
    function automatic logic [63:0] ref_result(muldiv_op_t op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 0;
        r  = 0;
        case (op)
            MD_MULT:  return 64'(sa * sb);
            MD_MULTU: return {32'b0, a} * {32'b0, b};
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Timing model: result lands LAT-1 enabled edges after accept, done one edge later.
    logic        m_busy, m_done, m_pend;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_rem;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_pend <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_rem  <= 0;
        end else if (clk_enable) begin
            if (m_pend) begin
                if (m_rem == 2) {m_hi, m_lo} <= m_res;
                if (m_rem == 1) m_done <= 1'b1;
                if (m_rem == 0) begin
                    m_done <= 1'b0;
                    m_busy <= 1'b0;
                    m_pend <= 1'b0;
                end
                m_rem <= m_rem - 1;
            end else if (bus.start && !m_busy) begin
                m_pend <= 1'b1;
                m_busy <= 1'b1;
                m_rem  <= LAT;
                m_res  <= ref_result(bus.op, bus.operand_a, bus.operand_b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_busy", bus.busy, m_busy);
            check("cyc_done", bus.done, m_done);
            check("cyc_hi",   bus.hi,   m_hi);
            check("cyc_lo",   bus.lo,   m_lo);
        end
    end

    // Called just after a posedge; the next posedge is the accept edge.
    task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk);
        #1 bus.start  = 1'b0;
    endtask

    task automatic run_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int stall_at, input int exp_lat);
        int k;
        issue(op, a, b);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (stall_at >= 0 && k == stall_at)      clk_enable = 1'b0;
            if (stall_at >= 0 && k == stall_at + 10) clk_enable = 1'b1;
            if (bus.done) break;
        end
        check({name, "_latency"}, 64'(k), 64'(exp_lat));
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        logic [31:0] cap_hi, cap_lo;

        reset         = 1'b1;
        clk_enable    = 1'b1;
        bus.start     = 1'b0;
        bus.op        = MD_MULT;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("multu_max",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, LAT);
        run_op("mult_neg",   MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, -1, LAT);
        run_op("div_neg",    MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, LAT);
        run_op("divu_small", MD_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, -1, LAT);
        run_op("div_ovf",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1, LAT);
        run_op("divu_zero",  MD_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, -1, LAT);
        run_op("div_zero_n", MD_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, -1, LAT);
        run_op("mult_minsq", MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -1, LAT);
        run_op("mult_mneg",  MD_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, -1, LAT);
        run_op("div_rem_p",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, -1, LAT);

        // Second start at accept+5 must be ignored.
        issue(MD_MULTU, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.op        = MD_DIVU;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd3;
        @(posedge clk);
        #1 bus.start  = 1'b0;
        pulses = 0;
        cap_hi = '0;
        cap_lo = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                cap_hi = bus.hi;
                cap_lo = bus.lo;
            end
        end
        check("dbl_pulses", 64'(pulses), 64'd1);
        check("dbl_result", {cap_hi, cap_lo}, 64'd42);
        @(posedge clk);
        #1;

        // Ten stalled cycles mid-RUN push done out by ten.
        run_op("stall", MD_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, 10, LAT + 10);

        // Reset at accept+10 (with clk_enable low, reset still wins).
        issue(MD_MULT, 32'd3, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        reset      = 1'b1;
        clk_enable = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        reset      = 1'b0;
        clk_enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("rst_mid_pulses", 64'(pulses), 64'd0);
        @(posedge clk);
        #1;

        run_op("after_rst", MD_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, -1, LAT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
